// File: rtl/lot_occupancy_display.sv
// Car-park occupancy counter: two-beam direction decoding, saturating BCD count
// with full/empty/error flags, and a multiplexed common-anode seven-segment driver.
module lot_occupancy_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int CAPACITY     = 99,
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_LZ     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a,
  input  logic                    b,
  output logic                    enter_pulse,
  output logic                    exit_pulse,
  output logic                    full,
  output logic                    empty,
  output logic                    err,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg
);

  localparam int CW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [CW-1:0] int_to_bcd(input int v);
    logic [CW-1:0] res;
    int r;
    res = '0;
    r   = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] res;
    logic          carry;
    logic [3:0]    d;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      res[4*i +: 4] = d;
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] res;
    logic          borrow;
    logic [3:0]    d;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      res[4*i +: 4] = d;
    end
    return res;
  endfunction

  // Segment order {dp,g,f,e,d,c,b,a}, active-low; non-decimal codes stay dark.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  localparam logic [CW-1:0] CAP_BCD = int_to_bcd(CAPACITY);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

  logic          a_p0, a_p1, b_p0, b_p1;
  logic [1:0]    ab;
  state_t        state_q, state_d;
  logic          entry_evt, exit_evt;
  logic [CW-1:0] cnt_q;

  // Stage p0/p1: two-flop synchronizers on the raw beam inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      a_p0 <= 1'b0;
      a_p1 <= 1'b0;
      b_p0 <= 1'b0;
      b_p1 <= 1'b0;
    end else begin
      a_p0 <= a;
      a_p1 <= a_p0;
      b_p0 <= b;
      b_p1 <= b_p0;
    end
  end

  assign ab = {a_p1, b_p1};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    entry_evt = 1'b0;
    exit_evt  = 1'b0;
    unique case (state_q)
      IDLE: if (ab == 2'b10) state_d = EN1;
            else if (ab == 2'b01) state_d = EX1;
      EN1:  if (ab == 2'b11) state_d = EN2;
            else if (ab == 2'b00) state_d = IDLE;
      EN2:  if (ab == 2'b01) state_d = EN3;
            else if (ab == 2'b10) state_d = EN1;
            else if (ab == 2'b00) state_d = IDLE;
      EN3:  if (ab == 2'b00) begin
              state_d   = IDLE;
              entry_evt = 1'b1;
            end else if (ab == 2'b11) state_d = EN2;
      EX1:  if (ab == 2'b11) state_d = EX2;
            else if (ab == 2'b00) state_d = IDLE;
      EX2:  if (ab == 2'b10) state_d = EX3;
            else if (ab == 2'b01) state_d = EX1;
            else if (ab == 2'b00) state_d = IDLE;
      EX3:  if (ab == 2'b00) begin
              state_d  = IDLE;
              exit_evt = 1'b1;
            end else if (ab == 2'b11) state_d = EX2;
      default: state_d = IDLE;
    endcase
  end

  // Stage p2: event pulses and count update land on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      err         <= 1'b0;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      enter_pulse <= entry_evt;
      exit_pulse  <= exit_evt;
      if (entry_evt) begin
        if (cnt_q == CAP_BCD) err <= 1'b1;
        else                  cnt_q <= bcd_inc(cnt_q);
      end else if (exit_evt) begin
        if (cnt_q == '0) err <= 1'b1;
        else             cnt_q <= bcd_dec(cnt_q);
      end
    end
  end

  assign count_bcd = cnt_q;
  assign full      = (cnt_q == CAP_BCD);
  assign empty     = (cnt_q == '0);

  logic [REFRESH_BITS-1:0] ref_cnt;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    nz;
  logic [3:0]              cur_digit;
  logic                    cur_blank;

  // Scanning from the top digit down, a digit is blanked until a nonzero digit is seen.
  always_comb begin
    blank     = '0;
    nz        = 1'b0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz       = nz | (cnt_q[4*i +: 4] != 4'd0);
      blank[i] = (BLANK_LZ != 0) && (i != 0) && !nz;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = cnt_q[4*i +: 4];
        cur_blank = blank[i];
      end
    end
  end

  // Display stage: refresh prescaler, digit index, registered anode/segment drive
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
      an      <= '1;
      sseg    <= 8'hFF;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
      if (&ref_cnt) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      an   <= ~(NUM_DIGITS'(1) << idx);
      sseg <= cur_blank ? 8'hFF : seg7(cur_digit);
    end
  end

endmodule

// File: tb/tb_lot_occupancy_display.sv
// Directed bench for lot_occupancy_display: two instances (capacity 12 and 9999)
// share clock, reset and beam inputs; a decimal model tracks each count.
module tb_lot_occupancy_display;

  logic clk = 1'b0;
  logic reset, a, b;
  always #5 clk = ~clk;

  logic        ep0, xp0, full0, empty0, err0;
  logic [15:0] cnt0;
  logic [3:0]  an0;
  logic [7:0]  sseg0;
  logic        ep1, xp1, full1, empty1, err1;
  logic [15:0] cnt1;
  logic [3:0]  an1;
  logic [7:0]  sseg1;

  lot_occupancy_display #(.NUM_DIGITS(4), .CAPACITY(12), .REFRESH_BITS(4), .BLANK_LZ(1)) dut0 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .enter_pulse(ep0), .exit_pulse(xp0), .full(full0), .empty(empty0), .err(err0),
    .count_bcd(cnt0), .an(an0), .sseg(sseg0));

  lot_occupancy_display #(.NUM_DIGITS(4), .CAPACITY(9999), .REFRESH_BITS(4), .BLANK_LZ(1)) dut1 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .enter_pulse(ep1), .exit_pulse(xp1), .full(full1), .empty(empty1), .err(err1),
    .count_bcd(cnt1), .an(an1), .sseg(sseg1));

  int pass_cnt = 0;
  int total    = 0;
  int m0, m1;
  int n_en0 = 0, n_ex0 = 0, n_en1 = 0, n_ex1 = 0;

  always @(negedge clk) begin
    if (ep0) n_en0++;
    if (xp0) n_ex0++;
    if (ep1) n_en1++;
    if (xp1) n_ex1++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1);
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic step(input logic va, input logic vb, input int n);
    a = va;
    b = vb;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_entry(input int h);
    step(1'b1, 1'b0, h); step(1'b1, 1'b1, h); step(1'b0, 1'b1, h); step(1'b0, 1'b0, h);
    if (m0 < 12) m0++;
    if (m1 < 9999) m1++;
  endtask

  task automatic do_exit(input int h);
    step(1'b0, 1'b1, h); step(1'b1, 1'b1, h); step(1'b1, 1'b0, h); step(1'b0, 1'b0, h);
    if (m0 > 0) m0--;
    if (m1 > 0) m1--;
  endtask

  task automatic do_reset();
    a = 1'b0; b = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m0 = 0; m1 = 0;
  endtask

  task automatic test_reset();
    logic [3:0] prev, exp_an;
    int k;
    a = 1'b0; b = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (cnt0 !== 16'h0000) $display("FAIL rst_count got %h expected 0000", cnt0); else pass_cnt++;
    total++; if (empty0 !== 1'b1) $display("FAIL rst_empty got %b expected 1", empty0); else pass_cnt++;
    total++; if (full0 !== 1'b0) $display("FAIL rst_full got %b expected 0", full0); else pass_cnt++;
    total++; if (err0 !== 1'b0) $display("FAIL rst_err got %b expected 0", err0); else pass_cnt++;
    total++; if (an0 !== 4'hF) $display("FAIL rst_an got %b expected 1111", an0); else pass_cnt++;
    total++; if (sseg0 !== 8'hFF) $display("FAIL rst_sseg got %h expected ff", sseg0); else pass_cnt++;
    total++; if ({ep0, xp0} !== 2'b00) $display("FAIL rst_pulses got %b expected 00", {ep0, xp0}); else pass_cnt++;
    reset = 1'b0;
    m0 = 0; m1 = 0;
    prev = 4'hF;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (an0 !== prev) begin
        exp_an = ~(4'b0001 << (k % 4));
        total++; if (an0 !== exp_an) $display("FAIL scan_an[%0d] got %b expected %b", k, an0, exp_an); else pass_cnt++;
        total++;
        if (sseg0 !== ((k % 4) == 0 ? 8'hC0 : 8'hFF))
          $display("FAIL scan_sseg[%0d] got %h expected %h", k, sseg0, ((k % 4) == 0 ? 8'hC0 : 8'hFF));
        else pass_cnt++;
        prev = an0;
        k++;
      end
    end
    total++; if (k !== 7) $display("FAIL scan_steps got %0d expected 7", k); else pass_cnt++;
    total++; if ({cnt0, empty0, full0, err0} !== {16'h0000, 3'b100}) $display("FAIL idle_state got %h %b%b%b expected 0000 100", cnt0, empty0, full0, err0); else pass_cnt++;
  endtask

  task automatic test_entry();
    int base_en, base_ex;
    base_en = n_en0;
    base_ex = n_ex0;
    step(1'b1, 1'b0, 8); step(1'b1, 1'b1, 8); step(1'b0, 1'b1, 8);
    a = 1'b0; b = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (ep0 !== 1'b0) $display("FAIL entry_early got %b expected 0", ep0); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (ep0 !== 1'b1) $display("FAIL entry_pulse got %b expected 1", ep0); else pass_cnt++;
    total++; if (cnt0 !== 16'h0001) $display("FAIL entry_count got %h expected 0001", cnt0); else pass_cnt++;
    total++; if (empty0 !== 1'b0) $display("FAIL entry_empty got %b expected 0", empty0); else pass_cnt++;
    step(1'b0, 1'b0, 5);
    total++; if (n_en0 - base_en !== 1) $display("FAIL entry_npulse got %0d expected 1", n_en0 - base_en); else pass_cnt++;
    total++; if (n_ex0 - base_ex !== 0) $display("FAIL entry_noexit got %0d expected 0", n_ex0 - base_ex); else pass_cnt++;
    m0 = 1; m1 = 1;
  endtask

  task automatic test_abort();
    int base_en, base_ex;
    base_en = n_en0;
    base_ex = n_ex0;
    step(1'b1, 1'b0, 6); step(1'b1, 1'b1, 6); step(1'b1, 1'b0, 6); step(1'b0, 1'b0, 6);
    total++; if ((n_en0 - base_en) + (n_ex0 - base_ex) !== 0) $display("FAIL abort_pulses got %0d expected 0", (n_en0 - base_en) + (n_ex0 - base_ex)); else pass_cnt++;
    total++; if (cnt0 !== 16'h0001) $display("FAIL abort_count got %h expected 0001", cnt0); else pass_cnt++;
  endtask

  task automatic test_exit();
    int base_ex;
    base_ex = n_ex0;
    do_exit(6);
    total++; if (n_ex0 - base_ex !== 1) $display("FAIL exit_npulse got %0d expected 1", n_ex0 - base_ex); else pass_cnt++;
    total++; if (cnt0 !== 16'h0000) $display("FAIL exit_count got %h expected 0000", cnt0); else pass_cnt++;
    total++; if ({empty0, err0} !== 2'b10) $display("FAIL exit_flags got %b expected 10", {empty0, err0}); else pass_cnt++;
  endtask

  task automatic test_capacity();
    int base_en;
    repeat (9) do_entry(4);
    total++; if (cnt0 !== 16'h0009) $display("FAIL cap_nine got %h expected 0009", cnt0); else pass_cnt++;
    do_entry(4);
    total++; if (cnt0 !== 16'h0010) $display("FAIL cap_carry got %h expected 0010", cnt0); else pass_cnt++;
    repeat (2) do_entry(4);
    total++; if ({cnt0, full0} !== {16'h0012, 1'b1}) $display("FAIL cap_full got %h %b expected 0012 1", cnt0, full0); else pass_cnt++;
    base_en = n_en0;
    do_entry(4);
    total++; if (cnt0 !== 16'h0012) $display("FAIL cap_sat got %h expected 0012", cnt0); else pass_cnt++;
    total++; if (err0 !== 1'b1) $display("FAIL cap_err got %b expected 1", err0); else pass_cnt++;
    total++; if (n_en0 - base_en !== 1) $display("FAIL cap_pulse got %0d expected 1", n_en0 - base_en); else pass_cnt++;
    total++; if (cnt1 !== to_bcd(m1)) $display("FAIL cap_big got %h expected %h", cnt1, to_bcd(m1)); else pass_cnt++;
    do_exit(4);
    total++; if ({cnt0, full0, err0} !== {16'h0011, 2'b01}) $display("FAIL cap_exit got %h %b%b expected 0011 01", cnt0, full0, err0); else pass_cnt++;
  endtask

  task automatic test_display_digits();
    logic [3:0] seen;
    logic [7:0] exp_seg;
    do_exit(4);
    total++; if (cnt0 !== 16'h0010) $display("FAIL disp_count got %h expected 0010", cnt0); else pass_cnt++;
    seen = 4'b0000;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!seen[i] && an0 === ~(4'b0001 << i)) begin
          exp_seg = (i == 0) ? 8'hC0 : (i == 1) ? 8'hF9 : 8'hFF;
          total++; if (sseg0 !== exp_seg) $display("FAIL disp_seg[%0d] got %h expected %h", i, sseg0, exp_seg); else pass_cnt++;
          seen[i] = 1'b1;
        end
      end
    end
    total++; if (seen !== 4'b1111) $display("FAIL disp_seen got %b expected 1111", seen); else pass_cnt++;
  endtask

  task automatic test_exit_empty();
    int base_ex;
    do_reset();
    base_ex = n_ex0;
    do_exit(4);
    total++; if (cnt0 !== 16'h0000) $display("FAIL xempty_count got %h expected 0000", cnt0); else pass_cnt++;
    total++; if ({err0, empty0} !== 2'b11) $display("FAIL xempty_flags got %b expected 11", {err0, empty0}); else pass_cnt++;
    total++; if (n_ex0 - base_ex !== 1) $display("FAIL xempty_pulse got %0d expected 1", n_ex0 - base_ex); else pass_cnt++;
    total++; if (err1 !== 1'b1) $display("FAIL xempty_err1 got %b expected 1", err1); else pass_cnt++;
  endtask

  task automatic test_carry_chain();
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      do_entry(3);
      total++; if (cnt1 !== to_bcd(m1)) $display("FAIL chain[%0d] got %h expected %h", m1, cnt1, to_bcd(m1)); else pass_cnt++;
      if (m1 == 999) begin
        total++; if (cnt1 !== 16'h0999) $display("FAIL chain_0999 got %h expected 0999", cnt1); else pass_cnt++;
      end
      if (m1 == 1000) begin
        total++; if (cnt1 !== 16'h1000) $display("FAIL chain_1000 got %h expected 1000", cnt1); else pass_cnt++;
      end
    end
    total++; if ({cnt0, full0, err0} !== {16'h0012, 2'b11}) $display("FAIL chain_small got %h %b%b expected 0012 11", cnt0, full0, err0); else pass_cnt++;
    total++; if (err1 !== 1'b0) $display("FAIL chain_err1 got %b expected 0", err1); else pass_cnt++;
  endtask

  task automatic test_reset_midseq();
    int base_en, base_ex;
    do_reset();
    repeat (5) do_entry(4);
    total++; if (cnt0 !== 16'h0005) $display("FAIL mid_five got %h expected 0005", cnt0); else pass_cnt++;
    step(1'b1, 1'b0, 5); step(1'b1, 1'b1, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({cnt0, err0} !== {16'h0000, 1'b0}) $display("FAIL mid_rst got %h %b expected 0000 0", cnt0, err0); else pass_cnt++;
    total++; if (an0 !== 4'hF) $display("FAIL mid_an got %b expected 1111", an0); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m0 = 0; m1 = 0;
    base_en = n_en0;
    base_ex = n_ex0;
    step(1'b1, 1'b1, 5); step(1'b0, 1'b1, 5); step(1'b0, 1'b0, 6);
    total++; if ((n_en0 - base_en) + (n_ex0 - base_ex) !== 0) $display("FAIL mid_noevent got %0d expected 0", (n_en0 - base_en) + (n_ex0 - base_ex)); else pass_cnt++;
    total++; if (cnt0 !== 16'h0000) $display("FAIL mid_count got %h expected 0000", cnt0); else pass_cnt++;
    do_entry(4);
    total++; if (cnt0 !== 16'h0001) $display("FAIL mid_fresh got %h expected 0001", cnt0); else pass_cnt++;
    total++; if (n_en0 - base_en !== 1) $display("FAIL mid_fresh_pulse got %0d expected 1", n_en0 - base_en); else pass_cnt++;
  endtask

  initial begin
    a = 1'b0;
    b = 1'b0;
    reset = 1'b1;
    m0 = 0;
    m1 = 0;
    test_reset();
    test_entry();
    test_abort();
    test_exit();
    test_capacity();
    test_display_digits();
    test_exit_empty();
    test_carry_chain();
    test_reset_midseq();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/lot_occupancy_display.md
Name: lot_occupancy_display

Overview:
- Parametrised car-park occupancy counter with a built-in multiplexed seven-segment driver.
- Decodes the order in which two beam sensors break (a = outer, b = inner) to detect cars entering and exiting.
- Keeps a saturating multi-digit BCD occupancy count and raises full, empty and error flags.
- Drives NUM_DIGITS common-anode digits directly; it is the next-generation single-block replacement for the lot counter/display top.

Parameters:
- NUM_DIGITS, 4, number of BCD digits counted and displayed (1..8).
- CAPACITY, 99, maximum occupancy; must be < 10^NUM_DIGITS.
- REFRESH_BITS, 18, width of the display refresh prescaler; the digit advances on each wrap.
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 always shown), 0 = show all digits.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- a, input, 1, outer beam sensor, 1 = beam broken, asynchronous.
- b, input, 1, inner beam sensor, 1 = beam broken, asynchronous.
- enter_pulse, output, 1, one-cycle pulse per counted entry attempt.
- exit_pulse, output, 1, one-cycle pulse per counted exit attempt.
- full, output, 1, count == CAPACITY.
- empty, output, 1, count == 0.
- err, output, 1, sticky: entry at full or exit at empty.
- count_bcd, output, 4*NUM_DIGITS, occupancy in BCD; digit 0 is in bits [3:0].
- an, output, NUM_DIGITS, digit enables, active-low, one-hot.
- sseg, output, 8, segments {dp,g,f,e,d,c,b,a}, active-low; dp is always 1.

Behaviour:
- Reset (synchronous, all state): count 0, FSM IDLE, synchronizers 0, err 0, pulses 0, empty 1, full 0, refresh counter 0, digit index 0, an all 1, sseg 8'hFF. Reset mid-sequence abandons the sequence with no event.
- Synchronizer: a and b pass through 2 flops each; the FSM sees only the synchronized sa and sb.
- Sensor FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3. Transitions on (sa,sb):
  - IDLE: 10 -> EN1; 01 -> EX1; 11 or 00 -> stay.
  - EN1: 11 -> EN2; 00 -> IDLE; else stay.
  - EN2: 01 -> EN3; 10 -> EN1; 00 -> IDLE; else stay.
  - EN3: 00 -> IDLE and entry event; 11 -> EN2; else stay.
  - EX1: 11 -> EX2; 00 -> IDLE; else stay.
  - EX2: 10 -> EX3; 01 -> EX1; 00 -> IDLE; else stay.
  - EX3: 00 -> IDLE and exit event; 11 -> EX2; else stay.
- Event latency: enter_pulse/exit_pulse are registered and high for the one cycle after the FSM leaves EN3/EX3. count_bcd, full and empty update in that same cycle.
- Entry and exit events are mutually exclusive by construction.
- Counting:
  - Entry with count < CAPACITY: BCD increment with decimal carry (digit 9 -> 0, carry to the next digit).
  - Entry with count == CAPACITY: count unchanged, err <= 1, enter_pulse still fires.
  - Exit with count > 0: BCD decrement with borrow (0 -> 9).
  - Exit with count == 0: count unchanged, err <= 1, exit_pulse still fires.
  - err clears only on reset.
- full and empty are combinational from the registered count.
- Display mux:
  - Refresh counter increments every cycle.
  - When it reaches all ones, the digit index advances 0..NUM_DIGITS-1, then wraps to 0.
  - an and sseg are registered and update the cycle after the index changes.
  - an[i] = 0 only for i == index.
  - sseg = hex-to-seven-segment of digit[index] (0-9 standard patterns).
  - With BLANK_LZ = 1, digit i > 0 is blanked (sseg = FF) when it and all higher digits are 0.
  - The display samples the live count; no freeze.

Test Plan:
- Reset, then hold a=b=0 for 100 cycles -> count_bcd 0, empty 1, full 0, err 0, an cycles 1110/1101/1011/0111 with REFRESH_BITS=4, digit 0 sseg 8'hC0, others 8'hFF.
- Drive (a,b) = 10, 11, 01, 00, each held 8 cycles -> exactly one enter_pulse, 3 cycles after 00 is applied; count 0001, empty 0.
- Entry sequence aborted at 10, 11, 10, 00 -> no pulse, count unchanged. Exit sequence 01, 11, 10, 00 from count 1 -> exit_pulse, count 0.
- CAPACITY=12: 9 entries -> count 0009; 10th -> 0010 (decimal carry); reach 12 -> full 1; 13th entry -> count stays 0012, err 1, enter_pulse seen. Then 1 exit -> 0011, full 0, err stays 1.
- Exit at empty -> count 0000, err 1. Then 1000 entries with CAPACITY=9999 checked against a decimal model; 0999 -> 1000 carry chain correct.
- Assert reset in EN2 with count 5 -> next cycle count 0, err 0, an all 1. Release in the 11 state and finish the sequence -> no event; a fresh full sequence counts normally.
